quadrature_decoder: RTL and testbench
=====================================

// Module: quadrature_decoder
// PURPOSE
//   Converts a 2-channel quadrature signal (A/B, e.g. a rotary encoder) into per-edge step
//   pulses, an up_down direction flag and a wrapping position count.
//   It produces the step/up_down stream that the team's up/down counters consume.
//   Sits at the chip-edge input path. Includes a synchronizer and a glitch filter.
// PARAMETERS
//   CNT_W        8  width of position counter
//   SYNC_STAGES  2  synchronizer flops per channel (>=2)
//   FILT_LEN     3  consecutive equal samples needed to accept a new channel level (>=1)
// PORTS
//   clk       in   1      single clock; all logic on posedge clk
//   reset     in   1      synchronous, active-low reset
//   enable    in   1      1: steps counted/emitted; 0: step suppressed, position holds
//   clear     in   1      synchronous position clear
//   quad_a    in   1      asynchronous channel A
//   quad_b    in   1      asynchronous channel B
//   step      out  1      one-cycle pulse per legal quadrature edge
//   up_down   out  1      direction of last legal edge: 1 up, 0 down; valid with step, then held
//   position  out  CNT_W  signed-agnostic count, wraps modulo 2^CNT_W
//   err       out  1      one-cycle pulse on an illegal transition (A and B change together)
//   err_seen  out  1      sticky err flag, cleared only by reset or clear
// BEHAVIOUR
//   Reset (reset==0 at posedge): step=0, up_down=1, position=0, err=0, err_seen=0.
//     Sync flops, filters and FSM cleared; primed=0.
//   Sync: each channel passes through SYNC_STAGES flops.
//   Filter: a channel's filtered level updates only after FILT_LEN consecutive equal
//     synchronized samples. Shorter pulses are discarded.
//   Priming: the first filtered {A,B} pair after reset loads the FSM state with no step or err.
//     primed is then set to 1.
//   FSM: 4 states, Gray-coded on {A,B}: S00, S01, S11, S10. Transitions:
//     S00->S01->S11->S10->S00 is up (up_down=1).
//     The reverse sequence is down (up_down=0).
//     A transition to the same state is no event.
//     A transition to the diagonal state (both bits differ) is illegal: err=1 for one cycle,
//       err_seen=1, no step, FSM adopts the new state.
//   Latency: a level change held stable on an input produces step exactly
//     SYNC_STAGES+FILT_LEN+1 cycles after the first posedge that samples it.
//     Latency is identical for every edge and both directions.
//   enable=0: FSM keeps tracking and err still reports; step stays 0; position and up_down hold.
//   position: +1 on an up step, -1 on a down step; 2^CNT_W-1 +1 -> 0; 0 -1 -> 2^CNT_W-1.
//   clear=1: position<=0 and err_seen<=0 next cycle. Clear wins over a coincident step.
//     That step is lost, but up_down still updates.
//   Simultaneous A and B edges that fall in different filter windows decode as two legal edges.
//   reset mid-operation: all state is discarded; priming repeats from the current input levels.
// STRUCTURE
//   Shared package quad_pkg:
//     - 2-bit state encodings: ST_00, ST_01, ST_11, ST_10
//     - DIR_UP=1'b1, DIR_DOWN=1'b0
//     - function quad_dir(prev,next) returning {legal, illegal, dir}
//   Sub-module quad_glitch_filter (params SYNC_STAGES, FILT_LEN; ports clk, reset, din, dout,
//     valid). Instantiated once per channel and includes the synchronizer.
//   Top holds the priming flag, FSM, position counter and error logic.
// TESTING
//   1 Inputs held at A=1,B=1 through reset release -> prime to S11; no step/err; position=0.
//   2 Four up edges (00->01->11->10->00), each held 10 cycles -> 4 step pulses, each at
//     latency 6 (defaults). up_down=1, position=4.
//   3 Continue down from position=1 for 3 edges -> position wraps to 254 (CNT_W=8); up_down=0.
//   4 2-cycle glitch on A, then 1-cycle glitch on A -> neither is accepted; no step; position
//     unchanged.
//   5 A and B toggled on the same cycle (00->11) -> err pulse 1 cycle, err_seen=1, no step.
//     A following legal edge from S11 counts normally.
//   6 clear asserted in the cycle step pulses -> position=0, up_down updated, err_seen=0.
//     enable=0 with 3 edges -> no step, position holds; re-enable -> next edge counts.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared encodings and the edge classifier for the quadrature decoder.
package quad_pkg;

  // Gray-coded {A,B} channel states.
  typedef enum logic [1:0] {
    ST_00 = 2'b00,
    ST_01 = 2'b01,
    ST_11 = 2'b11,
    ST_10 = 2'b10
  } quad_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Classification of one sampled transition.
  typedef struct packed {
    logic legal;
    logic illegal;
    logic dir;
  } quad_ev_t;

  // Successor in the up direction: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic quad_state_e quad_next_up(input quad_state_e s);
    case (s)
      ST_00:   return ST_01;
      ST_01:   return ST_11;
      ST_11:   return ST_10;
      default: return ST_00;
    endcase
  endfunction

  // Classify prev -> next: one-step forward is up, one-step backward is down,
  // both bits flipped is illegal, no change is no event.
  function automatic quad_ev_t quad_dir(input quad_state_e prev, input quad_state_e next);
    quad_ev_t ev;
    ev     = '0;
    ev.dir = DIR_UP;
    if (next == quad_next_up(prev)) begin
      ev.legal = 1'b1;
      ev.dir   = DIR_UP;
    end else if (prev == quad_next_up(next)) begin
      ev.legal = 1'b1;
      ev.dir   = DIR_DOWN;
    end else if ((prev ^ next) == 2'b11) begin
      ev.illegal = 1'b1;
    end
    return ev;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Per-channel synchronizer plus glitch filter. The filtered level changes only
// after FILT_LEN consecutive equal synchronized samples; valid rises with the
// first accepted level after reset.
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic valid
);

  // Cycles until the history holds only real samples (sync flops reset to 0
  // would otherwise look like a stable low level).
  localparam int FILL   = SYNC_STAGES + FILT_LEN;
  localparam int FILL_W = $clog2(FILL + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_LEN-1:0]    hist_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   filled;
  logic                   all_eq;

  assign filled = (fill_q == FILL_W'(FILL));
  assign all_eq = (&hist_q) | ~(|hist_q);

  // Synchronizer chain, sample history, fill counter and accepted level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= '0;
      fill_q <= '0;
      dout   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift from the
      // pre-edge value of its neighbour regardless of statement order.
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q[0] <= sync_q[SYNC_STAGES-1];
      for (int i = 1; i < FILT_LEN; i++) hist_q[i] <= hist_q[i-1];
      if (!filled) fill_q <= fill_q + FILL_W'(1);
      if (filled && all_eq) begin
        dout  <= hist_q[0];
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: filtered channels feed a Gray-code FSM producing
// step pulses, a direction flag, a wrapping position and illegal-edge errors.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             quad_a,
  input  logic             quad_b,
  output logic             step,
  output logic             up_down,
  output logic [CNT_W-1:0] position,
  output logic             err,
  output logic             err_seen
);

  logic a_f, b_f, a_vld, b_vld;

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .din(quad_a), .dout(a_f), .valid(a_vld)
  );

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .din(quad_b), .dout(b_f), .valid(b_vld)
  );

  quad_state_e      state_q, state_d, pair;
  logic             primed_q, primed_d;
  logic             step_d, up_down_d, err_d, err_seen_d;
  logic [CNT_W-1:0] position_d;
  quad_ev_t         ev;

  assign pair = quad_state_e'({a_f, b_f});
  assign ev   = quad_dir(state_q, pair);

  // State, flag and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_00;
      primed_q <= 1'b0;
      step     <= 1'b0;
      up_down  <= DIR_UP;
      position <= '0;
      err      <= 1'b0;
      err_seen <= 1'b0;
    end else begin
      state_q  <= state_d;
      primed_q <= primed_d;
      step     <= step_d;
      up_down  <= up_down_d;
      position <= position_d;
      err      <= err_d;
      err_seen <= err_seen_d;
    end
  end

  // Priming, transition decode, counting and clear priority.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d    = state_q;
    primed_d   = primed_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    up_down_d  = up_down;
    position_d = position;
    err_seen_d = err_seen;
    if (!primed_q) begin
      if (a_vld && b_vld) begin
        state_d  = pair;
        primed_d = 1'b1;
      end
    end else begin
      state_d = pair;
      if (ev.illegal) begin
        err_d      = 1'b1;
        err_seen_d = 1'b1;
      end
      if (ev.legal && enable) begin
        step_d     = 1'b1;
        up_down_d  = ev.dir;
        position_d = (ev.dir == DIR_UP) ? position + CNT_W'(1) : position - CNT_W'(1);
      end
    end
    // Clear overrides any coincident count; the direction update survives.
    if (clear) begin
      position_d = '0;
      err_seen_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed self-checking bench for quadrature_decoder (default parameters:
// CNT_W=8, SYNC_STAGES=2, FILT_LEN=3, so edge-to-step latency is 6 cycles).
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       step, up_down, err, err_seen;
  logic [7:0] position;

  int checks = 0;
  int failures = 0;

  localparam int LAT = 6;

  quadrature_decoder dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .quad_a(quad_a), .quad_b(quad_b), .step(step), .up_down(up_down),
    .position(position), .err(err), .err_seen(err_seen)
  );

  always #5 clk = ~clk;

  // Drive a new {A,B} level at a negedge and watch 12 following posedges.
  // Index 0 is the first posedge that samples the new level.
  task automatic apply_edge(input logic a, input logic b,
                            output int step_at, output int n_step,
                            output int err_at, output int n_err);
    @(negedge clk);
    quad_a = a;
    quad_b = b;
    step_at = -1; n_step = 0; err_at = -1; n_err = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (step) begin n_step++; if (step_at < 0) step_at = i; end
      if (err)  begin n_err++;  if (err_at < 0) err_at = i; end
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    reset = 1'b0; quad_a = a; quad_b = b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int sa, ns, ea, ne, nstep, nerr;
    do_reset(1'b1, 1'b1);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (step !== 1'b0)     begin failures++; $display("FAIL reset_step got=%b exp=0", step); end
    checks++; if (up_down !== 1'b1)  begin failures++; $display("FAIL reset_up_down got=%b exp=1", up_down); end
    checks++; if (position !== 8'd0) begin failures++; $display("FAIL reset_position got=%0d exp=0", position); end
    checks++; if (err !== 1'b0)      begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (err_seen !== 1'b0) begin failures++; $display("FAIL reset_err_seen got=%b exp=0", err_seen); end
    @(negedge clk); reset = 1'b1;
    nstep = 0; nerr = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (step) nstep++;
      if (err) nerr++;
    end
    checks++; if (nstep != 0 || nerr != 0 || position !== 8'd0)
      begin failures++; $display("FAIL prime_quiet steps=%0d errs=%0d pos=%0d exp 0/0/0", nstep, nerr, position); end
    // Primed to S11: 11->01 is a down edge.
    apply_edge(1'b0, 1'b1, sa, ns, ea, ne);
    checks++; if (sa != LAT || ns != 1 || ne != 0)
      begin failures++; $display("FAIL prime_s11_step at=%0d n=%0d errs=%0d exp %0d/1/0", sa, ns, ne, LAT); end
    checks++; if (up_down !== 1'b0 || position !== 8'd255)
      begin failures++; $display("FAIL prime_s11_dir ud=%b pos=%0d exp 0/255", up_down, position); end
  endtask

  task automatic test_up();
    int sa, ns, ea, ne;
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(1'b0, 1'b0);
    repeat (12) @(posedge clk); #1;
    checks++; if (position !== 8'd0 || step !== 1'b0)
      begin failures++; $display("FAIL rereset pos=%0d step=%b exp 0/0", position, step); end
    for (int k = 0; k < 4; k++) begin
      apply_edge(seq[k][1], seq[k][0], sa, ns, ea, ne);
      checks++; if (sa != LAT || ns != 1 || ne != 0 || up_down !== 1'b1)
        begin failures++; $display("FAIL up_edge%0d at=%0d n=%0d errs=%0d ud=%b exp %0d/1/0/1", k, sa, ns, ne, up_down, LAT); end
    end
    checks++; if (position !== 8'd4)
      begin failures++; $display("FAIL up_position got=%0d exp=4", position); end
  endtask

  task automatic test_down_wrap();
    int sa, ns, ea, ne;
    logic [1:0] seq [6];
    logic [7:0] exp_pos [6];
    seq     = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    exp_pos = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd255, 8'd254};
    for (int k = 0; k < 6; k++) begin
      apply_edge(seq[k][1], seq[k][0], sa, ns, ea, ne);
      checks++; if (sa != LAT || ns != 1 || position !== exp_pos[k] || up_down !== 1'b0)
        begin failures++; $display("FAIL down_edge%0d at=%0d n=%0d pos=%0d ud=%b exp %0d/1/%0d/0", k, sa, ns, position, up_down, LAT, exp_pos[k]); end
    end
  endtask

  task automatic test_glitch();
    int nstep, nerr;
    logic [31:0] a_pat;
    a_pat = ~32'h0000_0086;  // A low for cycles 1-2 and for cycle 7
    nstep = 0; nerr = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); quad_a = a_pat[i];
      @(posedge clk); #1;
      if (step) nstep++;
      if (err) nerr++;
    end
    checks++; if (nstep != 0 || nerr != 0 || position !== 8'd254)
      begin failures++; $display("FAIL glitch steps=%0d errs=%0d pos=%0d exp 0/0/254", nstep, nerr, position); end
  endtask

  task automatic test_err();
    int sa, ns, ea, ne;
    apply_edge(1'b1, 1'b0, sa, ns, ea, ne);  // 11->10 up
    apply_edge(1'b0, 1'b0, sa, ns, ea, ne);  // 10->00 up
    checks++; if (position !== 8'd0 || up_down !== 1'b1 || err_seen !== 1'b0)
      begin failures++; $display("FAIL pre_err pos=%0d ud=%b seen=%b exp 0/1/0", position, up_down, err_seen); end
    apply_edge(1'b1, 1'b1, sa, ns, ea, ne);  // 00->11 illegal
    checks++; if (ne != 1 || ea != LAT || ns != 0)
      begin failures++; $display("FAIL err_pulse n=%0d at=%0d steps=%0d exp 1/%0d/0", ne, ea, ns, LAT); end
    checks++; if (err_seen !== 1'b1 || position !== 8'd0)
      begin failures++; $display("FAIL err_sticky seen=%b pos=%0d exp 1/0", err_seen, position); end
    apply_edge(1'b1, 1'b0, sa, ns, ea, ne);  // 11->10 up
    checks++; if (sa != LAT || ns != 1 || position !== 8'd1 || err_seen !== 1'b1)
      begin failures++; $display("FAIL post_err at=%0d n=%0d pos=%0d seen=%b exp %0d/1/1/1", sa, ns, position, err_seen, LAT); end
  endtask

  task automatic test_clear();
    int sa, ns, ea, ne;
    apply_edge(1'b1, 1'b1, sa, ns, ea, ne);  // 10->11 down, position 0
    // 11->10 up; clear coincides with the edge that raises step.
    @(negedge clk); quad_a = 1'b1; quad_b = 1'b0;
    repeat (LAT) @(posedge clk);
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    checks++; if (step !== 1'b1 || position !== 8'd0 || up_down !== 1'b1 || err_seen !== 1'b0)
      begin failures++; $display("FAIL clear_win step=%b pos=%0d ud=%b seen=%b exp 1/0/1/0", step, position, up_down, err_seen); end
    @(negedge clk); clear = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++; if (position !== 8'd0)
      begin failures++; $display("FAIL clear_hold got=%0d exp=0", position); end
  endtask

  task automatic test_enable();
    int sa, ns, ea, ne, total;
    logic [1:0] seq [3];
    seq = '{2'b11, 2'b01, 2'b00};  // three down edges from S10
    @(negedge clk); enable = 1'b0;
    total = 0;
    for (int k = 0; k < 3; k++) begin
      apply_edge(seq[k][1], seq[k][0], sa, ns, ea, ne);
      total += ns;
    end
    checks++; if (total != 0 || position !== 8'd0 || up_down !== 1'b1)
      begin failures++; $display("FAIL disabled steps=%0d pos=%0d ud=%b exp 0/0/1", total, position, up_down); end
    @(negedge clk); enable = 1'b1;
    apply_edge(1'b1, 1'b0, sa, ns, ea, ne);  // 00->10 down
    checks++; if (sa != LAT || ns != 1 || position !== 8'd255 || up_down !== 1'b0)
      begin failures++; $display("FAIL reenable at=%0d n=%0d pos=%0d ud=%b exp %0d/1/255/0", sa, ns, position, up_down, LAT); end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down_wrap();
    test_glitch();
    test_err();
    test_clear();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
